parity_frame_acc: RTL

Parametrised successor to the fixed 3-input XNOR parity cell. It computes registered per-word parity over a WIDTH-bit input bus and accumulates parity across a frame of up to FRAME_LEN beats. At frame end it emits a frame parity result with beat count and a truncation flag. It sits between the digital stimulus sources and the downstream checker/logging logic in the mixed-signal test benches.

---
 rtl/parity_pkg.sv | 28 ++
 rtl/parity_word_reg.sv | 51 +++++
 rtl/parity_frame_acc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity frame accumulator:
//   - state_t   : frame FSM encoding (IDLE / ACTIVE)
//   - MAX_WIDTH : widest word red_par accepts; callers zero-extend into it
//   - red_par   : XOR reduction (zero-extension does not change the result)
//   - cw_of     : width of a beat counter able to hold 0..frame_len
// -----------------------------------------------------------------------------
package parity_pkg;

   localparam int MAX_WIDTH = 256;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Odd-ones detector; leading zero padding is parity-neutral.
   function automatic logic red_par(input logic [MAX_WIDTH-1:0] data);
      return ^data;
   endfunction

   // The count reaches frame_len itself, hence the +1.
   function automatic int cw_of(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

endpackage

// File: rtl/parity_word_reg.sv
// -----------------------------------------------------------------------------
// parity_word_reg
// Registered per-word parity. Each valid beat loads (^in_data) ^ INVERT.
// Idle cycles drop out_valid and leave out_parity unchanged.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : beat qualifier
//   in_data    : WIDTH-bit word
//   out_valid  : registered copy of in_valid
//   out_parity : registered word parity; held when no beat arrives
// -----------------------------------------------------------------------------
module parity_word_reg
   import parity_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter bit INVERT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             out_parity
);

   logic w_par;
   logic r_valid;
   logic r_parity;

   assign w_par = red_par(MAX_WIDTH'(in_data)) ^ INVERT;

   // Word parity register: load on a beat, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_parity <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_parity <= w_par;
         end else begin
            r_parity <= r_parity;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_parity = r_parity;

endmodule

// File: rtl/parity_frame_acc.sv
// -----------------------------------------------------------------------------
// parity_frame_acc
// Per-word registered parity plus a frame accumulator. It collects the XOR of
// every beat in a frame. A frame closes on in_last or when its length reaches
// FRAME_LEN. On a close it emits a one-cycle frame_valid pulse together with
// the frame parity, the beat count and a truncation flag. These values hold
// until the next close.
// Ports:
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   clear         : synchronous frame abort (wins over a same-cycle beat)
//   in_valid      : beat qualifier; every beat is accepted
//   in_data       : WIDTH-bit word
//   in_last       : last beat of a frame (only meaningful with in_valid)
//   out_valid     : word parity valid, one cycle after the beat
//   out_parity    : word parity, held between beats
//   frame_valid   : one-cycle pulse when a frame closes
//   frame_parity  : frame parity (INVERT polarity), held between pulses
//   frame_count   : beats in the closed frame, held between pulses
//   frame_trunc   : frame closed by the length limit, held between pulses
// -----------------------------------------------------------------------------
module parity_frame_acc
   import parity_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int FRAME_LEN = 8,
   parameter bit INVERT    = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear,
   input  logic                            in_valid,
   input  logic [WIDTH-1:0]                in_data,
   input  logic                            in_last,
   output logic                            out_valid,
   output logic                            out_parity,
   output logic                            frame_valid,
   output logic                            frame_parity,
   output logic [cw_of(FRAME_LEN)-1:0]     frame_count,
   output logic                            frame_trunc
);

   localparam int CW = cw_of(FRAME_LEN);

   // Frame state
   state_t          r_state;
   logic            r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_frame_valid;
   logic            r_frame_parity;
   logic [CW-1:0]   r_frame_count;
   logic            r_frame_trunc;

   // Combinational next values
   state_t          w_state_next;
   logic            w_acc_next;
   logic [CW-1:0]   w_cnt_next;
   logic            w_fv_next;
   logic            w_fp_next;
   logic [CW-1:0]   w_fc_next;
   logic            w_ft_next;

   logic            w_word_par;
   logic            w_acc_base;
   logic [CW-1:0]   w_cnt_base;
   logic            w_acc_beat;
   logic            w_at_limit;
   logic            w_close;

   parity_word_reg #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT)
   ) u_word (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_parity (out_parity)
   );

   // The accumulator always holds plain XOR; INVERT is applied only at the output.
   assign w_word_par = red_par(MAX_WIDTH'(in_data));

   // Frame FSM next-state and accumulator/result logic.
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_cnt_next   = r_cnt;
      w_fv_next    = 1'b0;
      w_fp_next    = r_frame_parity;
      w_fc_next    = r_frame_count;
      w_ft_next    = r_frame_trunc;

      // In IDLE no frame is open, so the running values are zero by
      // definition. Forcing them here keeps IDLE frames clean.
      case (r_state)
         IDLE: begin
            w_acc_base = 1'b0;
            w_cnt_base = {CW{1'b0}};
         end
         ACTIVE: begin
            w_acc_base = r_acc;
            w_cnt_base = r_cnt;
         end
         default: begin
            w_acc_base = 1'b0;
            w_cnt_base = {CW{1'b0}};
         end
      endcase

      w_acc_beat = w_acc_base ^ w_word_par;
      w_at_limit = (w_cnt_base == CW'(FRAME_LEN - 1));
      w_close    = in_valid & (in_last | w_at_limit);

      if (clear) begin
         // Abort: the same-cycle beat is dropped and no pulse is produced.
         w_state_next = IDLE;
         w_acc_next   = 1'b0;
         w_cnt_next   = {CW{1'b0}};
      end else if (w_close) begin
         w_state_next = IDLE;
         w_acc_next   = 1'b0;
         w_cnt_next   = {CW{1'b0}};
         w_fv_next    = 1'b1;
         w_fp_next    = w_acc_beat ^ INVERT;
         w_fc_next    = w_cnt_base + CW'(1);
         w_ft_next    = ~in_last;
      end else if (in_valid) begin
         // A non-closing beat can only happen when FRAME_LEN > 1.
         w_state_next = ACTIVE;
         w_acc_next   = w_acc_beat;
         w_cnt_next   = w_cnt_base + CW'(1);
      end else begin
         w_state_next = r_state;
         w_acc_next   = r_acc;
         w_cnt_next   = r_cnt;
      end
   end

   // Frame state and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_acc          <= 1'b0;
         r_cnt          <= {CW{1'b0}};
         r_frame_valid  <= 1'b0;
         r_frame_parity <= 1'b0;
         r_frame_count  <= {CW{1'b0}};
         r_frame_trunc  <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_acc          <= w_acc_next;
         r_cnt          <= w_cnt_next;
         r_frame_valid  <= w_fv_next;
         r_frame_parity <= w_fp_next;
         r_frame_count  <= w_fc_next;
         r_frame_trunc  <= w_ft_next;
      end
   end

   assign frame_valid  = r_frame_valid;
   assign frame_parity = r_frame_parity;
   assign frame_count  = r_frame_count;
   assign frame_trunc  = r_frame_trunc;

endmodule
